// File: rtl/dcache_pkg.sv
// Shared types and geometry for the data-cache controller.
package dcache_pkg;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned TAG_W     = 9;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned OFF_W     = 3;
  localparam int unsigned BLK_W     = 64;
  localparam int unsigned SETS      = 16;
  localparam int unsigned WAYS      = 2;
  localparam int unsigned MEM_TAG_W = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    LD_REQ  = 3'd2,
    LD_WAIT = 3'd3,
    FILL    = 3'd4
  } dc_state_t;

  // Request captured on a miss and replayed while the miss is serviced.
  typedef struct packed {
    logic             is_store;
    logic             victim;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [BLK_W-1:0] data;
  } req_t;

  // Block-aligned bus address from a tag/index pair.
  function automatic logic [ADDR_W-1:0] blk_addr(input logic [TAG_W-1:0] tag,
                                                 input logic [IDX_W-1:0] idx);
    return {tag, idx, OFF_W'(0)};
  endfunction

endpackage

// File: rtl/dcache_dirty_array.sv
// Per-set, per-way dirty flags with independent set and clear ports.
module dcache_dirty_array
  import dcache_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic             set_way,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic             clr_way,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic             rd_way,
  output logic             rd_dirty_c
);

  localparam int unsigned NBITS = SETS * WAYS;

  logic [NBITS-1:0] bits;

  // Flag update; set wins if both ports ever target the same flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      bits <= '0;
    end else begin
      if (clr_en) bits[{clr_idx, clr_way}] <= 1'b0;
      if (set_en) bits[{set_idx, set_way}] <= 1'b1;
    end
  end

  assign rd_dirty_c = bits[{rd_idx, rd_way}];

endmodule

// File: rtl/dcache_ctrl.sv
// Blocking write-allocate, write-back controller for the 2-way 16-set data cache.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_is_store,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [BLK_W-1:0]     req_data,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic [BLK_W-1:0]     resp_data,
  output logic [IDX_W-1:0]     cm_index,
  output logic [TAG_W-1:0]     cm_tag,
  output logic                 cm_wr_en,
  output logic [BLK_W-1:0]     cm_data,
  output logic                 cm_write_back,
  output logic                 cm_write_back_way,
  input  logic                 cm_hit_way0,
  input  logic                 cm_hit_way1,
  input  logic [BLK_W-1:0]     cm_data_out,
  input  logic [TAG_W-1:0]     cm_tag_out,
  input  logic                 cm_lru,
  output logic [1:0]           proc2mem_command,
  output logic [ADDR_W-1:0]    proc2mem_addr,
  output logic [BLK_W-1:0]     proc2mem_data,
  input  logic [MEM_TAG_W-1:0] mem2proc_response,
  input  logic [BLK_W-1:0]     mem2proc_data,
  input  logic [MEM_TAG_W-1:0] mem2proc_tag
);

  dc_state_t state, state_next;
  req_t      lat;
  logic [MEM_TAG_W-1:0] mem_tag;
  logic [BLK_W-1:0]     fetch_data;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic             hit, hit_way, bus_ack, tag_match, miss;
  logic             victim_dirty_c;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_way;
  logic             d_set, d_set_way, d_clr, d_clr_way;
  logic [IDX_W-1:0] d_set_idx, d_clr_idx;
  logic             unused_offset;

  assign req_tag   = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx   = req_addr[OFF_W +: IDX_W];
  assign hit       = cm_hit_way0 | cm_hit_way1;
  assign hit_way   = cm_hit_way1;
  assign miss      = (state == IDLE) && req_valid && !hit;
  assign bus_ack   = (mem2proc_response != '0);
  assign tag_match = (mem_tag != '0) && (mem2proc_tag == mem_tag);
  assign unused_offset = &{1'b0, req_addr[OFF_W-1:0]};

  // In IDLE the dirty lookup must follow the live request and the array's victim.
  assign rd_idx = (state == IDLE) ? req_idx : lat.idx;
  assign rd_way = (state == IDLE) ? cm_lru  : lat.victim;

  dcache_dirty_array u_dirty (
    .clock      (clock),
    .reset      (reset),
    .set_en     (d_set),
    .set_idx    (d_set_idx),
    .set_way    (d_set_way),
    .clr_en     (d_clr),
    .clr_idx    (d_clr_idx),
    .clr_way    (d_clr_way),
    .rd_idx     (rd_idx),
    .rd_way     (rd_way),
    .rd_dirty_c (victim_dirty_c)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state selection.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (miss) begin
          if (victim_dirty_c)    state_next = WB_REQ;
          else if (req_is_store) state_next = FILL;
          else                   state_next = LD_REQ;
        end
      end
      WB_REQ:  if (bus_ack) state_next = lat.is_store ? FILL : LD_REQ;
      LD_REQ:  if (bus_ack) state_next = LD_WAIT;
      LD_WAIT: if (tag_match) state_next = FILL;
      FILL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output and dirty-flag control decode.
  always_comb begin
    req_ready         = 1'b0;
    resp_valid        = 1'b0;
    resp_data         = '0;
    cm_index          = '0;
    cm_tag            = '0;
    cm_wr_en          = 1'b0;
    cm_data           = '0;
    cm_write_back     = 1'b0;
    cm_write_back_way = 1'b0;
    proc2mem_command  = BUS_NONE;
    proc2mem_addr     = '0;
    proc2mem_data     = '0;
    d_set             = 1'b0;
    d_set_idx         = '0;
    d_set_way         = 1'b0;
    d_clr             = 1'b0;
    d_clr_idx         = '0;
    d_clr_way         = 1'b0;
    if (reset) begin
      req_ready = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          req_ready = 1'b1;
          cm_index  = req_idx;
          cm_tag    = req_tag;
          if (req_valid && hit) begin
            if (req_is_store) begin
              cm_wr_en  = 1'b1;
              cm_data   = req_data;
              d_set     = 1'b1;
              d_set_idx = req_idx;
              d_set_way = hit_way;
            end else begin
              resp_valid = 1'b1;
              resp_data  = cm_data_out;
            end
          end
        end
        WB_REQ: begin
          cm_index          = lat.idx;
          cm_tag            = lat.tag;
          cm_write_back     = 1'b1;
          cm_write_back_way = lat.victim;
          proc2mem_command  = BUS_STORE;
          proc2mem_addr     = blk_addr(cm_tag_out, lat.idx);
          proc2mem_data     = cm_data_out;
          if (bus_ack) begin
            d_clr     = 1'b1;
            d_clr_idx = lat.idx;
            d_clr_way = lat.victim;
          end
        end
        LD_REQ: begin
          cm_index         = lat.idx;
          cm_tag           = lat.tag;
          proc2mem_command = BUS_LOAD;
          proc2mem_addr    = blk_addr(lat.tag, lat.idx);
        end
        LD_WAIT: begin
          cm_index = lat.idx;
          cm_tag   = lat.tag;
        end
        FILL: begin
          cm_index = lat.idx;
          cm_tag   = lat.tag;
          cm_wr_en = 1'b1;
          cm_data  = lat.is_store ? lat.data : fetch_data;
          if (lat.is_store) begin
            d_set     = 1'b1;
            d_set_idx = lat.idx;
            d_set_way = lat.victim;
          end else begin
            d_clr      = 1'b1;
            d_clr_idx  = lat.idx;
            d_clr_way  = lat.victim;
            resp_valid = 1'b1;
            resp_data  = fetch_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Miss context, bus transaction tag and returned fill data.
  always_ff @(posedge clock) begin
    if (reset) begin
      lat        <= '0;
      mem_tag    <= '0;
      fetch_data <= '0;
    end else begin
      if (miss) lat <= {req_is_store, cm_lru, req_tag, req_idx, req_data};
      if ((state == LD_REQ) && bus_ack) mem_tag <= mem2proc_response;
      if ((state == LD_WAIT) && tag_match) fetch_data <= mem2proc_data;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench: behavioural cache array, tagged memory and a cache reference model.
module tb_dcache_ctrl;

  logic        clock, reset;
  logic        req_valid, req_is_store;
  logic [15:0] req_addr;
  logic [63:0] req_data;
  logic        req_ready, resp_valid;
  logic [63:0] resp_data;
  logic [3:0]  cm_index;
  logic [8:0]  cm_tag;
  logic        cm_wr_en;
  logic [63:0] cm_data;
  logic        cm_write_back, cm_write_back_way;
  logic        cm_hit_way0, cm_hit_way1;
  logic [63:0] cm_data_out;
  logic [8:0]  cm_tag_out;
  logic        cm_lru;
  logic [1:0]  proc2mem_command;
  logic [15:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;

  int checks = 0;
  int errors = 0;

  dcache_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_is_store(req_is_store), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_data(resp_data), .cm_index(cm_index), .cm_tag(cm_tag),
    .cm_wr_en(cm_wr_en), .cm_data(cm_data), .cm_write_back(cm_write_back),
    .cm_write_back_way(cm_write_back_way), .cm_hit_way0(cm_hit_way0),
    .cm_hit_way1(cm_hit_way1), .cm_data_out(cm_data_out), .cm_tag_out(cm_tag_out),
    .cm_lru(cm_lru), .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
    .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- behavioural 2-way array (replaces least-recently-written way)
  logic [8:0]  a_tag [16][2];
  logic        a_val [16][2];
  logic [63:0] a_dat [16][2];
  logic        a_lru [16];
  logic        arr_clr;
  logic        rd_way, wr_way;

  always_comb begin
    cm_hit_way0 = a_val[cm_index][0] && (a_tag[cm_index][0] == cm_tag);
    cm_hit_way1 = a_val[cm_index][1] && (a_tag[cm_index][1] == cm_tag);
    cm_lru      = a_lru[cm_index];
    rd_way      = cm_write_back ? cm_write_back_way : cm_hit_way1;
    cm_data_out = a_dat[cm_index][rd_way];
    cm_tag_out  = a_tag[cm_index][rd_way];
    wr_way      = cm_hit_way0 ? 1'b0 : (cm_hit_way1 ? 1'b1 : a_lru[cm_index]);
  end

  always_ff @(posedge clock) begin
    if (arr_clr) begin
      for (int s = 0; s < 16; s++) begin
        a_lru[s]    <= 1'b0;
        a_val[s][0] <= 1'b0;
        a_val[s][1] <= 1'b0;
      end
    end else if (cm_wr_en) begin
      a_tag[cm_index][wr_way] <= cm_tag;
      a_val[cm_index][wr_way] <= 1'b1;
      a_dat[cm_index][wr_way] <= cm_data;
      a_lru[cm_index]         <= ~wr_way;
    end
  end

  // ---------------- memory image and processor-visible golden image
  logic [63:0] mem [int];
  logic [63:0] golden [int];

  function automatic logic [63:0] mem_rd(input logic [15:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return {16'hC0DE, a, 16'hBEEF, ~a};
  endfunction

  function automatic logic [63:0] g_rd(input logic [15:0] a);
    if (golden.exists(int'(a))) return golden[int'(a)];
    return mem_rd(a);
  endfunction

  // ---------------- reference cache: residency, dirtiness and contents per way
  logic [8:0]  r_tag [16][2];
  logic        r_val [16][2];
  logic        r_dirty [16][2];
  logic [63:0] r_dat [16][2];
  logic        r_lru [16];

  // ---------------- per-transaction observations
  logic [1:0]  log_cmd [$];
  logic [15:0] log_addr [$];
  logic [63:0] log_data [$];
  int          o_resp_cnt, o_resp_cyc, o_wr_cyc, o_ready_cyc, o_rej_seen;
  logic [63:0] o_resp_data, o_wr_data;
  logic [3:0]  o_wr_idx;
  bit          o_accept, o_hold_bad;

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; arr_clr = 1'b1; req_valid = 1'b0;
    mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0; arr_clr = 1'b0;
    for (int s = 0; s < 16; s++) begin
      r_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        r_val[s][w] = 1'b0; r_dirty[s][w] = 1'b0; r_tag[s][w] = '0; r_dat[s][w] = '0;
      end
    end
    golden.delete();
  endtask

  // Drives one request and plays the memory bus until the controller is ready again.
  task automatic xact(input bit st, input logic [15:0] addr, input logic [63:0] data,
                      input int rej, input int lat, input bit bad);
    int cyc, cnt, rej_left;
    bit pending, bad_left, done, holding;
    logic [1:0]  held_cmd;
    logic [15:0] held_addr, ld_blk;
    log_cmd.delete(); log_addr.delete(); log_data.delete();
    o_resp_cnt = 0; o_resp_cyc = -1; o_wr_cyc = -1; o_ready_cyc = -1; o_rej_seen = 0;
    o_resp_data = '0; o_wr_data = '0; o_wr_idx = '0; o_hold_bad = 0; o_accept = 0;
    held_cmd = '0; held_addr = '0; ld_blk = '0;
    cyc = 0; cnt = 0; rej_left = rej; pending = 0; bad_left = bad; done = 0; holding = 0;
    @(negedge clock);
    req_valid = 1'b1; req_is_store = st; req_addr = addr; req_data = data;
    while (!done && cyc < 300) begin
      #1;
      if (cyc == 0) o_accept = req_ready;
      else if (req_ready) begin o_ready_cyc = cyc; done = 1; end
      if (!done) begin
        if (resp_valid) begin o_resp_cnt++; o_resp_cyc = cyc; o_resp_data = resp_data; end
        if (cm_wr_en) begin o_wr_cyc = cyc; o_wr_idx = cm_index; o_wr_data = cm_data; end
        if (proc2mem_command != 2'd0) begin
          if (holding && (proc2mem_command !== held_cmd || proc2mem_addr !== held_addr))
            o_hold_bad = 1;
          if (rej_left > 0) begin
            rej_left--; o_rej_seen++; holding = 1;
            held_cmd = proc2mem_command; held_addr = proc2mem_addr;
          end else begin
            holding = 0;
            mem2proc_response = 4'd3;
            log_cmd.push_back(proc2mem_command);
            log_addr.push_back(proc2mem_addr);
            log_data.push_back(proc2mem_data);
            if (proc2mem_command == 2'd2) mem[int'(proc2mem_addr)] = proc2mem_data;
            else begin pending = 1; cnt = lat; ld_blk = proc2mem_addr; end
          end
        end else if (pending && !cm_wr_en) begin
          if (cnt > 1) cnt--;
          else if (bad_left) begin
            mem2proc_tag = 4'd5; mem2proc_data = ~mem_rd(ld_blk); bad_left = 0;
          end else begin
            mem2proc_tag = 4'd3; mem2proc_data = mem_rd(ld_blk); pending = 0;
          end
        end
        @(negedge clock);
        req_valid = 1'b0; mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
        cyc++;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout addr=%h: req_ready never returned within %0d cycles", addr, cyc);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; arr_clr = 1'b1; req_valid = 1'b0; req_is_store = 1'b0;
    req_addr = '0; req_data = '0;
    mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
    @(negedge clock);
    @(negedge clock);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    checks++; if (cm_wr_en !== 1'b0 || cm_write_back !== 1'b0) begin errors++; $display("FAIL reset_cm_ctrl got wr=%b wb=%b want 0 0", cm_wr_en, cm_write_back); end
    checks++; if (proc2mem_command !== 2'd0 || proc2mem_addr !== 16'h0) begin errors++; $display("FAIL reset_bus got cmd=%0d addr=%h want 0 0", proc2mem_command, proc2mem_addr); end
    checks++; if (resp_data !== 64'h0 || cm_data !== 64'h0 || cm_index !== 4'h0) begin errors++; $display("FAIL reset_data got resp=%h cm=%h idx=%h want 0", resp_data, cm_data, cm_index); end
    do_reset();
  endtask

  task automatic test_load_miss_hit();
    mem[16'h0080] = 64'h0000_0000_AAAA_5555;
    xact(1'b0, 16'h0080, '0, 0, 4, 0);
    checks++; if (o_accept !== 1'b1) begin errors++; $display("FAIL lmiss_accept got %b want 1", o_accept); end
    checks++; if (log_cmd.size() != 1 || log_cmd[0] !== 2'd1 || log_addr[0] !== 16'h0080) begin errors++; $display("FAIL lmiss_bus got n=%0d want one BUS_LOAD 0080", log_cmd.size()); end
    checks++; if (o_resp_cnt != 1 || o_resp_data !== 64'hAAAA_5555) begin errors++; $display("FAIL lmiss_data got cnt=%0d data=%h want 1 aaaa5555", o_resp_cnt, o_resp_data); end
    checks++; if (o_resp_cyc != 6 || o_ready_cyc != 7) begin errors++; $display("FAIL lmiss_timing got resp@%0d ready@%0d want 6 7", o_resp_cyc, o_ready_cyc); end
    xact(1'b0, 16'h0080, '0, 0, 4, 0);
    checks++; if (o_resp_cyc != 0 || o_resp_data !== 64'hAAAA_5555 || log_cmd.size() != 0) begin errors++; $display("FAIL lhit got resp@%0d data=%h bus=%0d want 0 aaaa5555 0", o_resp_cyc, o_resp_data, log_cmd.size()); end
  endtask

  task automatic test_store_hit_evict();
    xact(1'b1, 16'h0080, 64'h1234, 0, 1, 0);
    checks++; if (o_wr_cyc != 0 || o_wr_idx !== 4'd0 || o_wr_data !== 64'h1234 || log_cmd.size() != 0) begin errors++; $display("FAIL shit got wr@%0d idx=%0d data=%h bus=%0d want 0 0 1234 0", o_wr_cyc, o_wr_idx, o_wr_data, log_cmd.size()); end
    checks++; if (o_ready_cyc != 1 || o_resp_cnt != 0) begin errors++; $display("FAIL shit_ready got ready@%0d resp=%0d want 1 0", o_ready_cyc, o_resp_cnt); end
    // 0x0100 takes the empty way; 0x0180 then displaces the dirty 0x0080 line.
    xact(1'b0, 16'h0100, '0, 0, 2, 0);
    checks++; if (log_cmd.size() != 1 || log_cmd[0] !== 2'd1 || log_addr[0] !== 16'h0100) begin errors++; $display("FAIL fill0100_bus got n=%0d want one BUS_LOAD", log_cmd.size()); end
    xact(1'b0, 16'h0180, '0, 0, 2, 0);
    checks++; if (log_cmd.size() != 2 || log_cmd[0] !== 2'd2 || log_addr[0] !== 16'h0080 || log_data[0] !== 64'h1234) begin errors++; $display("FAIL evict_wb got n=%0d want BUS_STORE 0080 1234 first", log_cmd.size()); end
    checks++; if (log_cmd.size() != 2 || log_cmd[1] !== 2'd1 || log_addr[1] !== 16'h0180) begin errors++; $display("FAIL evict_ld got n=%0d want BUS_LOAD 0180 second", log_cmd.size()); end
    checks++; if (o_resp_data !== mem_rd(16'h0180)) begin errors++; $display("FAIL evict_data got %h want %h", o_resp_data, mem_rd(16'h0180)); end
  endtask

  task automatic test_store_miss_clean();
    xact(1'b1, 16'h0200, 64'hDEAD_BEEF_0000_0001, 0, 1, 0);
    checks++; if (log_cmd.size() != 0) begin errors++; $display("FAIL smiss_bus got %0d cmds want 0", log_cmd.size()); end
    checks++; if (o_wr_cyc != 1 || o_wr_data !== 64'hDEAD_BEEF_0000_0001) begin errors++; $display("FAIL smiss_fill got wr@%0d data=%h want 1 deadbeef00000001", o_wr_cyc, o_wr_data); end
    checks++; if (o_ready_cyc != 2 || o_resp_cnt != 0) begin errors++; $display("FAIL smiss_ready got ready@%0d resp=%0d want 2 0", o_ready_cyc, o_resp_cnt); end
  endtask

  task automatic test_bus_retry();
    xact(1'b0, 16'h0308, '0, 3, 2, 0);
    checks++; if (o_rej_seen != 3 || o_hold_bad) begin errors++; $display("FAIL retry_hold got rejects=%0d unstable=%0d want 3 0", o_rej_seen, o_hold_bad); end
    checks++; if (log_cmd.size() != 1 || log_addr[0] !== 16'h0308) begin errors++; $display("FAIL retry_bus got n=%0d want one BUS_LOAD 0308", log_cmd.size()); end
    checks++; if (o_resp_cyc != 7 || o_resp_data !== mem_rd(16'h0308)) begin errors++; $display("FAIL retry_resp got resp@%0d data=%h want 7 %h", o_resp_cyc, o_resp_data, mem_rd(16'h0308)); end
  endtask

  task automatic test_wrong_tag();
    xact(1'b0, 16'h0410, '0, 0, 3, 1);
    checks++; if (o_resp_cnt != 1 || o_resp_data !== mem_rd(16'h0410)) begin errors++; $display("FAIL wtag_data got cnt=%0d data=%h want 1 %h", o_resp_cnt, o_resp_data, mem_rd(16'h0410)); end
    checks++; if (o_resp_cyc != 6) begin errors++; $display("FAIL wtag_timing got resp@%0d want 6", o_resp_cyc); end
  endtask

  task automatic test_reset_in_wait();
    int bad_cnt;
    xact(1'b1, 16'h0028, 64'h5151, 0, 1, 0);
    @(negedge clock);
    req_valid = 1'b1; req_is_store = 1'b0; req_addr = 16'h0530;
    @(negedge clock);
    req_valid = 1'b0;
    #1;
    checks++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 16'h0530) begin errors++; $display("FAIL rst_ldreq got cmd=%0d addr=%h want 1 0530", proc2mem_command, proc2mem_addr); end
    mem2proc_response = 4'd3;
    @(negedge clock);
    mem2proc_response = '0;
    #1;
    checks++; if (proc2mem_command !== 2'd0 || req_ready !== 1'b0) begin errors++; $display("FAIL rst_wait got cmd=%0d ready=%b want 0 0", proc2mem_command, req_ready); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    mem2proc_tag = 4'd3; mem2proc_data = 64'hFFFF_0000_FFFF_0000;
    bad_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (resp_valid !== 1'b0 || cm_wr_en !== 1'b0 || req_ready !== 1'b1) bad_cnt++;
      @(negedge clock);
      mem2proc_tag = '0; mem2proc_data = '0;
    end
    checks++; if (bad_cnt != 0) begin errors++; $display("FAIL rst_late_tag got %0d cycles with fill/resp/busy want 0", bad_cnt); end
    // The 0x0028 line stays in the array but must no longer be dirty.
    xact(1'b0, 16'h00A8, '0, 0, 1, 0);
    xact(1'b0, 16'h0128, '0, 0, 1, 0);
    checks++; if (log_cmd.size() != 1 || log_cmd[0] !== 2'd1) begin errors++; $display("FAIL rst_dirty_clear got n=%0d first=%0d want one BUS_LOAD", log_cmd.size(), log_cmd.size() > 0 ? log_cmd[0] : 2'd0); end
  endtask

  task automatic test_random();
    logic [15:0] addr, blk, vaddr;
    logic [3:0]  set;
    logic [8:0]  tg;
    logic [63:0] data, exp;
    bit          st, hitv, exp_wb;
    int          hw, v, nexp;
    do_reset();
    for (int n = 0; n < 200; n++) begin
      tg   = 9'($urandom_range(0, 3));
      set  = 4'($urandom_range(0, 3));
      addr = {tg, set, 3'($urandom_range(0, 7))};
      blk  = {addr[15:3], 3'b000};
      st   = 1'($urandom_range(0, 1));
      data = {$urandom, $urandom};
      hw   = -1;
      for (int w = 0; w < 2; w++) if (r_val[set][w] && r_tag[set][w] == tg) hw = w;
      hitv = (hw >= 0);
      xact(st, addr, data, $urandom_range(0, 2), $urandom_range(1, 4), 1'($urandom_range(0, 3) == 0));
      if (hitv) begin
        checks++; if (o_ready_cyc != 1 || log_cmd.size() != 0) begin errors++; $display("FAIL rnd_hit n=%0d addr=%h got ready@%0d bus=%0d want 1 0", n, addr, o_ready_cyc, log_cmd.size()); end
        if (st) begin
          r_dat[set][hw] = data; r_dirty[set][hw] = 1'b1; r_lru[set] = (hw == 0);
        end
      end else begin
        v      = int'(r_lru[set]);
        exp_wb = r_val[set][v] && r_dirty[set][v];
        vaddr  = {r_tag[set][v], set, 3'b000};
        nexp   = int'(exp_wb) + int'(!st);
        checks++; if (log_cmd.size() != nexp) begin errors++; $display("FAIL rnd_bus_count n=%0d addr=%h got %0d want %0d", n, addr, log_cmd.size(), nexp); end
        if (exp_wb && log_cmd.size() > 0) begin
          checks++; if (log_cmd[0] !== 2'd2 || log_addr[0] !== vaddr || log_data[0] !== r_dat[set][v]) begin errors++; $display("FAIL rnd_wb n=%0d got cmd=%0d addr=%h data=%h want 2 %h %h", n, log_cmd[0], log_addr[0], log_data[0], vaddr, r_dat[set][v]); end
        end
        if (!st && log_cmd.size() == nexp) begin
          checks++; if (log_cmd[nexp-1] !== 2'd1 || log_addr[nexp-1] !== blk) begin errors++; $display("FAIL rnd_ld n=%0d got cmd=%0d addr=%h want 1 %h", n, log_cmd[nexp-1], log_addr[nexp-1], blk); end
        end
        r_tag[set][v] = tg; r_val[set][v] = 1'b1; r_dirty[set][v] = st;
        r_dat[set][v] = st ? data : g_rd(blk); r_lru[set] = (v == 0);
      end
      if (!st) begin
        exp = g_rd(blk);
        checks++; if (o_resp_cnt != 1 || o_resp_data !== exp) begin errors++; $display("FAIL rnd_load n=%0d addr=%h got cnt=%0d data=%h want 1 %h", n, addr, o_resp_cnt, o_resp_data, exp); end
      end else begin
        golden[int'(blk)] = data;
        checks++; if (o_resp_cnt != 0) begin errors++; $display("FAIL rnd_store_resp n=%0d got %0d resp want 0", n, o_resp_cnt); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_miss_hit();
    test_store_hit_evict();
    test_store_miss_clean();
    test_bus_retry();
    test_wrong_tag();
    test_reset_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
